// File: rtl/uart_pkg.sv
// uart_pkg: shared state codes, line levels and frame constants for the UART TX/RX blocks
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        TX_DATA    = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        TX_SENT    = 3'd5
    } tx_state_e;

    localparam logic TX_IDLE  = 1'b1;
    localparam logic TX_START = 1'b0;
    localparam logic TX_STOP  = 1'b1;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter, strobes on the last cycle of each period
module uart_bit_timer #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic end_bit_time
);
    localparam int W = $clog2(BAUD_DIV);
    localparam logic [W-1:0] LAST = W'(BAUD_DIV - 1);

    logic [W-1:0] tmr_q, tmr_d;

    assign end_bit_time = en && (tmr_q == LAST);

    // hold at zero while disabled, otherwise count and wrap on the strobe
    always_comb begin
        tmr_d = (!en || end_bit_time) ? '0 : tmr_q + 1'b1;
    end

    // timer register
    always_ff @(posedge clk) begin
        if (rst) tmr_q <= '0;
        else     tmr_q <= tmr_d;
    end

endmodule

// File: rtl/uart_tx_datapath.sv
// uart_tx_datapath: UART TX byte latch, bit timing, parity and registered line; parity slot enabled by UART_TX_PARITY_EN
module uart_tx_datapath
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 434,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_send,
    input  logic [7:0] tx_data,
    input  logic [2:0] tx_state,
    input  logic       tx_cntr_en,
    input  logic       bit_tmr_en,
    output logic       end_bit_time,
    output logic [3:0] tx_bit_count,
    output logic       tx,
    output logic       tx_busy
);
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 par;

    uart_bit_timer #(
        .BAUD_DIV(BAUD_DIV)
    ) u_bit_timer (
        .clk          (clk),
        .rst          (rst),
        .en           (bit_tmr_en),
        .end_bit_time (end_bit_time)
    );

`ifdef UART_TX_PARITY_EN
    assign par = ^data_q ^ PARITY_ODD;
`else
    // without parity the slot is a second stop bit
    assign par = TX_STOP;
`endif

    // byte capture, saturating data-bit count and next line level
    always_comb begin
        data_d = (tx_state == IDLE && tx_send) ? tx_data : data_q;
        cnt_d  = !tx_cntr_en ? '0
               : (end_bit_time && cnt_q < 4'(DATA_BITS)) ? cnt_q + 4'd1 : cnt_q;
        tx_d   = (tx_state == IDLE)       ? TX_IDLE
               : (tx_state == START_BIT)  ? TX_START
               : (tx_state == TX_DATA)    ? ((cnt_q < 4'(DATA_BITS)) ? data_q[cnt_q[2:0]] : par)
               : (tx_state == PARITY_BIT) ? par
               : TX_STOP;
    end

    // datapath registers; tx is registered so it trails tx_state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
            tx_q   <= TX_IDLE;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            tx_q   <= tx_d;
            busy_q <= (tx_state != IDLE);
        end
    end

    assign tx_bit_count = cnt_q;
    assign tx           = tx_q;
    assign tx_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_datapath.sv
// tb_uart_tx_datapath: randomized frames against a slot-level line model, with even and odd parity instances
module tb_uart_tx_datapath;
    import uart_pkg::*;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_send = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [2:0] st;
    logic       tmr_en, cntr_en;
    logic       ebt_e, ebt_o, tx_e, tx_o, busy_e, busy_o;
    logic [3:0] cnt_e, cnt_o;
    int         n_run = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_datapath #(.BAUD_DIV(BD), .PARITY_ODD(1'b0)) dut_e (
        .clk(clk), .rst(rst), .tx_send(tx_send), .tx_data(tx_data), .tx_state(st),
        .tx_cntr_en(cntr_en), .bit_tmr_en(tmr_en), .end_bit_time(ebt_e),
        .tx_bit_count(cnt_e), .tx(tx_e), .tx_busy(busy_e)
    );

    uart_tx_datapath #(.BAUD_DIV(BD), .PARITY_ODD(1'b1)) dut_o (
        .clk(clk), .rst(rst), .tx_send(tx_send), .tx_data(tx_data), .tx_state(st),
        .tx_cntr_en(cntr_en), .bit_tmr_en(tmr_en), .end_bit_time(ebt_o),
        .tx_bit_count(cnt_o), .tx(tx_o), .tx_busy(busy_o)
    );

    // control FSM that sits alongside the datapath
    assign tmr_en  = (st == START_BIT) || (st == TX_DATA) || (st == PARITY_BIT) || (st == STOP_BIT);
    assign cntr_en = (st == TX_DATA);

    always @(posedge clk) begin
        if (rst) st <= IDLE;
        else case (st)
            IDLE:       if (tx_send) st <= START_BIT;
            START_BIT:  if (ebt_e) st <= TX_DATA;
            TX_DATA:    if (cnt_e == 4'd8) st <= PARITY_BIT;
            PARITY_BIT: if (ebt_e) st <= STOP_BIT;
            STOP_BIT:   if (ebt_e) st <= TX_SENT;
            default:    st <= IDLE;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected line level of frame slot 0..10: start, 8 data LSB first, parity, stop
    function automatic logic slot_bit(input logic [7:0] d, input bit odd, input int slot);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return logic'((d >> (slot - 1)) & 8'h01);
        if (slot == 9) begin
`ifdef UART_TX_PARITY_EN
            return logic'((ones % 2) ^ int'(odd));
`else
            return 1'b1;
`endif
        end
        return 1'b1;
    endfunction

    // one frame; poke_at pulses tx_send with 0xFF mid-frame, abort_at asserts rst mid-frame
    task automatic send_frame(input logic [7:0] d, input int poke_at, input int abort_at);
        int max_cnt = 0;
        @(negedge clk);
        tx_send = 1'b1;
        tx_data = d;
        @(negedge clk);
        tx_send = 1'b0;
        tx_data = ~d;
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            if (k == abort_at + 1) begin
                check("rst_tx_e", tx_e, 1);
                check("rst_tx_o", tx_o, 1);
                check("rst_cnt", cnt_e, 0);
                check("rst_busy", busy_e, 0);
                rst = 1'b0;
                return;
            end
            check($sformatf("tx_e[%0d]", k), tx_e, (k <= 44) ? slot_bit(d, 1'b0, (k - 1) / BD) : 1'b1);
            check($sformatf("tx_o[%0d]", k), tx_o, (k <= 44) ? slot_bit(d, 1'b1, (k - 1) / BD) : 1'b1);
            check($sformatf("busy[%0d]", k), busy_e, k <= 45);
            check("busy_o", busy_o, busy_e);
            check("cnt_le8", cnt_e <= 4'd8, 1);
            if (int'(cnt_e) > max_cnt) max_cnt = int'(cnt_e);
            tx_send = (k == poke_at);
            tx_data = (k == poke_at) ? 8'hFF : tx_data;
            if (k == abort_at) rst = 1'b1;
        end
        check("cnt_peak", max_cnt, 8);
        repeat (3) begin
            @(negedge clk);
            check("idle_busy", busy_e, 0);
            check("idle_tx", tx_e, 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_idle_tx", tx_e, 1);
            check("rst_idle_busy", busy_e, 0);
            check("rst_idle_cnt", cnt_e, 0);
            check("rst_idle_ebt", ebt_e, 0);
        end
        send_frame(8'hA5, -1, -1);
        send_frame(8'h01, -1, -1);
        send_frame(8'h00, -1, -1);
        send_frame(8'hA5, 20, -1);
        send_frame(8'h5A, -1, 14);
        send_frame(8'h3C, -1, -1);
        for (int n = 0; n < 10; n++)
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : -1, -1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_datapath.md
# uart_tx_datapath

UART transmit datapath that sits directly downstream of the UART TX control FSM. It consumes the FSM's state code and enables, and returns the two status signals that drive the FSM's transitions: the bit-period strobe and the data-bit count. It latches the byte to send, generates per-bit timing, computes parity and drives the registered serial line `tx`.

## Interface
Parameters:
- `BAUD_DIV`, default 434: clock cycles per bit (50 MHz / 115200). Legal range is `BAUD_DIV >= 2`.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `tx_send`  in  1  send request; sampled only while `tx_state == IDLE`.
- `tx_data`  in  8  byte to transmit; captured with `tx_send`.
- `tx_state`  in  3  FSM state code: IDLE=0, START_BIT=1, TX_DATA=2, PARITY_BIT=3, STOP_BIT=4, TX_SENT=5.
- `tx_cntr_en`  in  1  bit-counter enable.
- `bit_tmr_en`  in  1  bit-timer enable.
- `end_bit_time`  out  1  combinational strobe, high on the last cycle of each bit period.
- `tx_bit_count`  out  4  number of data bits completed, 0..8.
- `tx`  out  1  serial line, registered.
- `tx_busy`  out  1  registered; high whenever `tx_state != IDLE`.

## Operation
Data latch:
- When `tx_state == IDLE` and `tx_send == 1`, load `data_q <= tx_data`.
- `tx_send` in any other state is ignored. `tx_data` changes outside the load cycle are ignored.

Parity:
- Parity is computed from `data_q` as `^data_q ^ PARITY_ODD`.

Bit timer (`tmr`, width `$clog2(BAUD_DIV)`):
- `bit_tmr_en == 0`: `tmr <= 0`.
- `bit_tmr_en == 1`: `tmr` counts 0..`BAUD_DIV-1` and wraps to 0.
- `end_bit_time = bit_tmr_en && (tmr == BAUD_DIV-1)`.

Bit counter:
- `tx_cntr_en == 0`: `tx_bit_count <= 0`.
- `tx_cntr_en == 1` and `end_bit_time` and count < 8: increment.
- Saturates at 8 and never wraps.

Line select (`tx_next`), registered into `tx` every cycle:
- IDLE: 1.
- START_BIT: 0.
- TX_DATA: `data_q[tx_bit_count]` if count < 8, else parity. LSB is sent first.
- PARITY_BIT: parity.
- STOP_BIT: 1.
- TX_SENT: 1.
- Undefined codes 6 and 7: 1.

Reset values:
- `tx = 1`, `tx_busy = 0`, `tx_bit_count = 0`, `tmr = 0`, `data_q = 0`.
- `end_bit_time` is 0 because the FSM holds `bit_tmr_en` low.
- `rst` asserted mid-frame returns every register to its reset value on the next edge; `tx` goes high with no partial bit emitted afterwards.

## Timing
- `tx` lags `tx_state` by exactly one cycle. Every bit duration is preserved.
- Start, each data bit, parity and stop each last exactly `BAUD_DIV` cycles on `tx`.
- The FSM detects count==8 one cycle after bit 7 ends. In that cycle `tmr` has already wrapped to 0 and the line already shows parity, so the parity bit is not stretched.
- Frame length from the first `tx` low cycle to the end of stop is `11*BAUD_DIV` cycles. TX_SENT adds 1 cycle of idle-high.
- Back-to-back frames: the minimum gap between stop end and the next start is 2 cycles (TX_SENT, then IDLE with `tx_send`).
- `end_bit_time` and `tmr` are simultaneous with FSM state edges. No skew is allowed between them.

## Configuration
- `UART_TX_PARITY_EN` defined: the parity slot carries the computed parity as described above.
- `UART_TX_PARITY_EN` undefined: the parity logic is removed and the parity slot (PARITY_BIT, and TX_DATA with count==8) drives 1. That slot acts as a second stop bit; frame timing is unchanged.

## Structure
- Package `uart_pkg`:
  - State codes IDLE..TX_SENT (3-bit).
  - Line constants TX_IDLE=1, TX_START=0, TX_STOP=1.
  - `DATA_BITS = 8`.
- Sub-module `uart_bit_timer`: parameter `BAUD_DIV`, inputs `clk`, `rst`, `en`, output `end_bit_time`. It is reused by the RX side.

## Test plan
Scenarios run with `BAUD_DIV = 4` and the FSM instantiated alongside the block.
- Reset, no send: `tx = 1`, `tx_busy = 0`, `tx_bit_count = 0` for 20 cycles.
- Send 0xA5, even parity, macro defined: `tx` sequence per 4-cycle slot is 0,1,0,1,0,0,1,0,1,0,1. `tx` is low 1 cycle after START_BIT entry. The frame is 44 cycles, then `tx` is high.
- Send 0x01 with `PARITY_ODD = 1`: parity slot is 0. With `PARITY_ODD = 0`: parity slot is 1.
- During a frame, toggle `tx_data` to 0xFF and pulse `tx_send`: the frame is unchanged and no second frame starts. `tx_bit_count` peaks at 8 and never reaches 9.
- Assert `rst` at the 3rd data bit: the next cycle shows `tx = 1`, `tx_bit_count = 0`, `tx_busy = 0`. A following send of 0x3C transmits correctly.
- Macro undefined, send 0x00: the parity slot reads 1 and the frame length is still 44 cycles.
